pipe_hazard_ctrl: RTL and testbench

- Central stall/flush controller driving the EN/flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline latches of the 5-stage RISC-V core.
- Detects load-use hazards, taken-branch redirects, multi-cycle data-memory waits, and trap/mret redirects.
- Sequences the matching freeze/bubble pattern and keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush controller for the 5-stage core. Drives the enable
//   and flush pins of the IF/ID, ID/EX, EX/MEM and MEM/WB latches plus the
//   PC source select, and keeps saturating stall / redirect counters.
//
// Ports
//   clk, rst                  core clock, async active-low reset
//   rs1_ID, rs2_ID            ID-stage source register addresses
//   rs1_used_ID, rs2_used_ID  ID instruction actually reads rs1 / rs2
//   rd_EX, mem_r_EX           EX destination and "EX is a load"
//   branch_taken_EX           EX resolved a taken branch/jump
//   mem_busy                  MEM-stage data access still outstanding
//   trap_MEM, mret_MEM        trap / mret committed in MEM
//   en_PC .. en_MEMWB         latch enables
//   flush_IFID .. flush_MEMWB bubble insert (only meaningful with enable=1)
//   pc_sel                    0 PC+4, 1 branch target, 2 mtvec, 3 mepc
//   bus_err                   sticky memory-timeout flag
//   stall_cnt, flush_cnt      saturating performance counters
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TRAP_DRAIN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [4:0]  rd_EX,
  input  logic        mem_r_EX,
  input  logic        branch_taken_EX,
  input  logic        mem_busy,
  input  logic        trap_MEM,
  input  logic        mret_MEM,
  output logic        en_PC,
  output logic        en_IFID,
  output logic        en_IDEX,
  output logic        en_EXMEM,
  output logic        en_MEMWB,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        flush_EXMEM,
  output logic        flush_MEMWB,
  output logic [1:0]  pc_sel,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int DW = (TRAP_DRAIN < 2) ? 1 : $clog2(TRAP_DRAIN + 1);

  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(TRAP_DRAIN);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_MWAIT = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_MTVEC = 2'd2;
  localparam logic [1:0] PC_MEPC  = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic          r_bus_err;
  logic [31:0]   r_stall_cnt, r_flush_cnt;

  logic w_run;         // RUN priority logic owns this cycle
  logic w_take_redir;  // trap/mret redirect accepted this cycle
  logic w_load_use;
  logic w_redir_evt;
  logic w_berr_set;

  // MWAIT falls through to the RUN priority logic in the same cycle mem_busy
  // drops. Any unused state encoding is treated as RUN.
  assign w_run = ((r_state != S_MWAIT) && (r_state != S_DRAIN)) ||
                 ((r_state == S_MWAIT) && !mem_busy);

  // Traps are only taken from RUN-like cycles or DRAIN; a trap seen while
  // MEM is still busy waits until the access completes.
  assign w_take_redir = (trap_MEM || mret_MEM) && (w_run || (r_state == S_DRAIN));

  // x0 is never a real dependency.
  assign w_load_use = mem_r_EX && (rd_EX != 5'd0) &&
                      ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                       (rs2_used_ID && (rs2_ID == rd_EX)));

  always_comb begin
    en_PC       = 1'b1;
    en_IFID     = 1'b1;
    en_IDEX     = 1'b1;
    en_EXMEM    = 1'b1;
    en_MEMWB    = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    flush_MEMWB = 1'b0;
    pc_sel      = PC_SEQ;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_drain_nxt = r_drain;
    w_redir_evt = 1'b0;
    w_berr_set  = 1'b0;

    // While reset is asserted the outputs sit at their reset values even if
    // inputs would otherwise request a freeze.
    if (rst) begin
      if (w_take_redir) begin
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        flush_EXMEM = 1'b1;
        pc_sel      = trap_MEM ? PC_MTVEC : PC_MEPC;
        w_redir_evt = 1'b1;
        w_wait_nxt  = '0;
        w_drain_nxt = DRAIN_INIT;
        w_state_nxt = S_DRAIN;
      end else if (w_run) begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
        if (mem_busy) begin
          en_PC       = 1'b0;
          en_IFID     = 1'b0;
          en_IDEX     = 1'b0;
          en_EXMEM    = 1'b0;
          flush_MEMWB = 1'b1;
          w_wait_nxt  = WW'(1);
          w_berr_set  = (WAIT_MAX <= WW'(1));
          w_state_nxt = S_MWAIT;
        end else if (branch_taken_EX) begin
          flush_IFID  = 1'b1;
          flush_IDEX  = 1'b1;
          pc_sel      = PC_BR;
          w_redir_evt = 1'b1;
        end else if (w_load_use) begin
          // One-cycle hold: next cycle EX holds the bubble and the hazard clears.
          en_PC      = 1'b0;
          en_IFID    = 1'b0;
          flush_IDEX = 1'b1;
        end
      end else if (r_state == S_MWAIT) begin
        en_PC       = 1'b0;
        en_IFID     = 1'b0;
        en_IDEX     = 1'b0;
        en_EXMEM    = 1'b0;
        flush_MEMWB = 1'b1;
        if (r_wait < WAIT_MAX)
          w_wait_nxt = r_wait + WW'(1);
        w_berr_set = (w_wait_nxt >= WAIT_MAX);
      end else begin
        // DRAIN: IF/ID keeps eating bubbles while the redirected fetch settles.
        en_PC      = 1'b0;
        flush_IFID = 1'b1;
        if (r_drain <= DW'(1)) begin
          w_drain_nxt = '0;
          w_state_nxt = S_RUN;
        end else begin
          w_drain_nxt = r_drain - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait      <= '0;
      r_drain     <= '0;
      r_bus_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_drain <= w_drain_nxt;
      if (w_berr_set)
        r_bus_err <= 1'b1;
      if (!en_PC && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redir_evt && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign bus_err   = r_bus_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk, rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        rs1_used_ID, rs2_used_ID, mem_r_EX, branch_taken_EX;
  logic        mem_busy, trap_MEM, mret_MEM;
  logic        en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic        flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
  logic [1:0]  pc_sel;
  logic        bus_err;
  logic [31:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(255), .TRAP_DRAIN(2)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .mem_r_EX(mem_r_EX),
    .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
    .trap_MEM(trap_MEM), .mret_MEM(mret_MEM),
    .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX),
    .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .flush_EXMEM(flush_EXMEM), .flush_MEMWB(flush_MEMWB),
    .pc_sel(pc_sel), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {en_PC,en_IFID,en_IDEX,en_EXMEM,en_MEMWB, flush IFID,IDEX,EXMEM,MEMWB, pc_sel}
  logic [10:0] obs;
  assign obs = {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
                flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB, pc_sel};

  localparam logic [10:0] P_RUN  = 11'b11111_0000_00;
  localparam logic [10:0] P_LU   = 11'b00111_0100_00;
  localparam logic [10:0] P_BR   = 11'b11111_1100_01;
  localparam logic [10:0] P_FRZ  = 11'b00001_0001_00;
  localparam logic [10:0] P_TRAP = 11'b11111_1110_10;
  localparam logic [10:0] P_MRET = 11'b11111_1110_11;
  localparam logic [10:0] P_DRN  = 11'b01111_1000_00;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        mr, br;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[9];
  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    rd_EX = 5'd0; mem_r_EX = 1'b0; branch_taken_EX = 1'b0;
    mem_busy = 1'b0; trap_MEM = 1'b0; mret_MEM = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
    chk({tag, "_flush_cnt"}, flush_cnt, exp_flush);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, P_RUN, "no_dep_load"};
    tbl[1] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, P_LU,  "lu_rs2"};
    tbl[2] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, P_RUN, "lu_rd_x0"};
    tbl[3] = '{5'd7, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, P_LU,  "lu_rs1"};
    tbl[4] = '{5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, P_RUN, "rs1_unused"};
    tbl[5] = '{5'd7, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, P_RUN, "dep_not_load"};
    tbl[6] = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, P_BR,  "branch_over_lu"};
    tbl[7] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, P_BR,  "branch_only"};
    tbl[8] = '{5'd1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, P_RUN, "rs2_unused"};

    // Reset state
    rst = 1'b0;
    idle();
    #2;
    chk("rst_outputs", obs, P_RUN);
    chk("rst_bus_err", bus_err, 0);
    chk_cnt("rst");
    @(negedge clk); rst = 1'b1;

    // Single load-use stall: x5 loaded, ID reads rs2=x5
    @(negedge clk);
    rd_EX = 5'd5; mem_r_EX = 1'b1; rs2_ID = 5'd5; rs2_used_ID = 1'b1;
    rs1_ID = 5'd1; rs1_used_ID = 1'b1;
    #1 chk("lu_single", obs, P_LU);
    @(negedge clk); idle();
    #1 chk("lu_release", obs, P_RUN);
    exp_stall = 1;
    chk_cnt("lu_single");

    // Table-driven combinational vectors in RUN
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rs1_ID = tbl[i].rs1; rs2_ID = tbl[i].rs2;
      rs1_used_ID = tbl[i].u1; rs2_used_ID = tbl[i].u2;
      rd_EX = tbl[i].rd; mem_r_EX = tbl[i].mr; branch_taken_EX = tbl[i].br;
      #1 chk(tbl[i].name, obs, tbl[i].exp);
      if (tbl[i].exp[10] == 1'b0) exp_stall++;
      if (tbl[i].exp[1:0] == 2'd1) exp_flush++;
    end
    @(negedge clk); idle();
    #1 chk_cnt("table");

    // mem_busy held 4 cycles
    @(negedge clk); mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("mwait_frz_%0d", k), obs, P_FRZ);
      @(negedge clk);
    end
    mem_busy = 1'b0;
    #1 chk("mwait_exit_run", obs, P_RUN);
    chk("mwait_bus_err", bus_err, 0);
    exp_stall += 4;
    chk_cnt("mwait4");

    // trap+mret together, then drain with branch/load-use ignored
    @(negedge clk); trap_MEM = 1'b1; mret_MEM = 1'b1;
    #1 chk("trap_wins", obs, P_TRAP);
    exp_flush++;
    @(negedge clk); trap_MEM = 1'b0; mret_MEM = 1'b0;
    branch_taken_EX = 1'b1; mem_r_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; rs2_used_ID = 1'b1;
    #1 chk("drain1_ignores", obs, P_DRN);
    @(negedge clk); idle();
    #1 chk("drain2", obs, P_DRN);
    @(negedge clk);
    #1 chk("drain_done", obs, P_RUN);
    exp_stall += 2;
    chk_cnt("trap");

    // mret then a new trap during DRAIN restarts the sequence
    @(negedge clk); mret_MEM = 1'b1;
    #1 chk("mret_redirect", obs, P_MRET);
    exp_flush++;
    @(negedge clk); mret_MEM = 1'b0; trap_MEM = 1'b1;
    #1 chk("drain_restart", obs, P_TRAP);
    exp_flush++;
    @(negedge clk); trap_MEM = 1'b0;
    #1 chk("restart_drain1", obs, P_DRN);
    @(negedge clk);
    #1 chk("restart_drain2", obs, P_DRN);
    @(negedge clk);
    #1 chk("restart_done", obs, P_RUN);
    exp_stall += 2;
    chk_cnt("restart");

    // trap held off while memory is busy, taken as soon as it completes
    @(negedge clk); mem_busy = 1'b1;
    #1 chk("mw_trap_frz0", obs, P_FRZ);
    @(negedge clk); trap_MEM = 1'b1;
    #1 chk("mw_trap_ignored", obs, P_FRZ);
    @(negedge clk); mem_busy = 1'b0;
    #1 chk("mw_exit_trap", obs, P_TRAP);
    exp_stall += 2; exp_flush++;
    @(negedge clk); trap_MEM = 1'b0;
    #1 chk("mw_trap_drain1", obs, P_DRN);
    @(negedge clk);
    #1 chk("mw_trap_drain2", obs, P_DRN);
    @(negedge clk);
    #1 chk("mw_trap_done", obs, P_RUN);
    exp_stall += 2;
    chk_cnt("mw_trap");

    // Memory timeout: bus_err at wait count 255, sticky
    @(negedge clk); mem_busy = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      #1;
      if (k == 254) chk("berr_before_timeout", bus_err, 0);
      if (k == 255) chk("berr_at_timeout", bus_err, 1);
      if (k == 300) chk("timeout_still_frz", obs, P_FRZ);
    end
    mem_busy = 1'b0;
    #1 chk("timeout_exit_run", obs, P_RUN);
    exp_stall += 300;
    @(negedge clk);
    #1 chk("berr_sticky", bus_err, 1);
    chk_cnt("timeout");

    // Async reset in the middle of MWAIT
    @(negedge clk); mem_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_rst_outputs", obs, P_RUN);
    chk("async_rst_bus_err", bus_err, 0);
    exp_stall = 0; exp_flush = 0;
    chk_cnt("async_rst");
    @(negedge clk); mem_busy = 1'b0; rst = 1'b1;
    #1 chk("post_rst_run", obs, P_RUN);
    @(negedge clk);
    #1 chk_cnt("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
